// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared load-op codes, FSM states and widths
// for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LB      = 3'd1,
    LBU     = 3'd2,
    LH      = 3'd3,
    LHU     = 3'd4,
    LW      = 3'd5,
    LWL     = 3'd6,
    LWR     = 3'd7
  } ld_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/ld_align.sv
// ld_align: combinational load alignment and extension,
// producing the final value and a per-byte regfile write mask.
module ld_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        ld_op,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] value,
  output logic [3:0]        wen
);

  logic [7:0]  b;
  logic [15:0] h;

  // Select the addressed byte/half, then extend or merge by load type.
  always_comb begin
    unique case (addr)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = addr[1] ? raw[31:16] : raw[15:0];
    value = raw;
    wen = 4'b1111;
    unique case (ld_op)
      LB:  value = {{24{b[7]}}, b};
      LBU: value = {24'b0, b};
      LH, LHU: begin
        if (addr[0]) begin
          value = '0;
          wen = 4'b0000;
        end else if (ld_op == LH) begin
          value = {{16{h[15]}}, h};
        end else begin
          value = {16'b0, h};
        end
      end
      LWL: begin
        unique case (addr)
          2'd0: begin
            value = {raw[7:0], 24'b0};
            wen = 4'b1000;
          end
          2'd1: begin
            value = {raw[15:0], 16'b0};
            wen = 4'b1100;
          end
          2'd2: begin
            value = {raw[23:0], 8'b0};
            wen = 4'b1110;
          end
          default: value = raw;
        endcase
      end
      LWR: begin
        unique case (addr)
          2'd1: begin
            value = {8'b0, raw[31:8]};
            wen = 4'b0111;
          end
          2'd2: begin
            value = {16'b0, raw[31:16]};
            wen = 4'b0011;
          end
          2'd3: begin
            value = {24'b0, raw[31:24]};
            wen = 4'b0001;
          end
          default: value = raw;
        endcase
      end
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: valid/allowin MEM stage waiting on load data.
// Define MEM_STAGE_FLUSH_EN for flush and stale-response cancel.
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEST_W   = 5,
  parameter int unsigned WB_OP_W  = 3,
  parameter logic [31:0] PC_RESET = 32'hbfc00000,
  parameter int unsigned CANCEL_W = 2
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MEM_STAGE_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               exe_valid,
  output logic               mem_allowin,
  input  logic [2:0]         exe_ld_op,
  input  logic [WB_OP_W-1:0] exe_wb_op,
  input  logic [DEST_W-1:0]  exe_dest,
  input  logic [31:0]        exe_value,
  input  logic [31:0]        exe_pc,
  input  logic               data_rvalid,
  input  logic [31:0]        data_rdata,
  input  logic               wb_allowin,
  output logic               mem_valid,
  output logic               mem_ready_go,
  output logic [WB_OP_W-1:0] mem_wb_op,
  output logic [DEST_W-1:0]  mem_dest,
  output logic [31:0]        mem_value,
  output logic [3:0]         mem_wen,
  output logic [31:0]        mem_pc
);

  state_e              state_q, state_d;
  logic [2:0]          ld_op_q, ld_op_d;
  logic [WB_OP_W-1:0]  wb_op_q, wb_op_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                buf_vld_q, buf_vld_d;
  logic                flush_w, drop;
  logic                rvalid_hit, handoff, accept;
  logic [DATA_W-1:0]   raw, al_value;
  logic [3:0]          al_wen;

`ifdef MEM_STAGE_FLUSH_EN
  logic [CANCEL_W-1:0] cancel_q, cancel_d;
  logic                cancel_inc;

  assign flush_w = flush;
  assign drop = data_rvalid && (cancel_q != '0);
`else
  logic [CANCEL_W-1:0] cancel_unused;

  assign cancel_unused = '0;
  assign flush_w = 1'b0;
  assign drop = 1'b0;
`endif

  assign rvalid_hit = data_rvalid && !drop
                   && (state_q == WAIT);
  assign mem_valid = (state_q != EMPTY);
  assign mem_ready_go = (state_q == FULL) || rvalid_hit;
  assign handoff = mem_ready_go && wb_allowin;
  assign mem_allowin = !mem_valid || handoff;
  assign accept = exe_valid && mem_allowin && !flush_w;

  assign raw = (ld_op_q == LD_NONE) ? value_q
             : buf_vld_q ? buf_q : data_rdata;

  ld_align u_align (
    .ld_op (ld_op_q),
    .addr  (value_q[1:0]),
    .raw   (raw),
    .value (al_value),
    .wen   (al_wen)
  );

  assign mem_value = mem_valid ? al_value : '0;
  assign mem_wen = mem_valid ? al_wen : 4'b0000;
  assign mem_wb_op = wb_op_q;
  assign mem_dest = dest_q;
  assign mem_pc = pc_q;

  // Next-state: capture data, hand off, accept; flush wins.
  always_comb begin
    state_d = state_q;
    ld_op_d = ld_op_q;
    wb_op_d = wb_op_q;
    dest_d = dest_q;
    value_d = value_q;
    pc_d = pc_q;
    buf_d = buf_q;
    buf_vld_d = buf_vld_q;
    if (rvalid_hit) begin
      state_d = FULL;
      buf_d = data_rdata;
      buf_vld_d = 1'b1;
    end
    if (handoff) begin
      state_d = EMPTY;
      buf_vld_d = 1'b0;
    end
    if (accept) begin
      if (exe_ld_op != LD_NONE) state_d = WAIT;
      else state_d = FULL;
      ld_op_d = exe_ld_op;
      wb_op_d = exe_wb_op;
      dest_d = exe_dest;
      value_d = exe_value;
      pc_d = exe_pc;
      buf_vld_d = 1'b0;
    end
    if (flush_w) begin
      state_d = EMPTY;
      buf_vld_d = 1'b0;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      ld_op_q <= '0;
      wb_op_q <= '0;
      dest_q <= '0;
      value_q <= '0;
      pc_q <= PC_RESET;
      buf_q <= '0;
      buf_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_op_q <= ld_op_d;
      wb_op_q <= wb_op_d;
      dest_q <= dest_d;
      value_q <= value_d;
      pc_q <= pc_d;
      buf_q <= buf_d;
      buf_vld_q <= buf_vld_d;
    end
  end

`ifdef MEM_STAGE_FLUSH_EN
  // Count responses still owed to loads squashed while waiting.
  always_comb begin
    cancel_inc = flush && (state_q == WAIT) && !rvalid_hit;
    cancel_d = cancel_q;
    if (drop && !cancel_inc)
      cancel_d = cancel_q - CANCEL_W'(1);
    else if (!drop && cancel_inc && (cancel_q != '1))
      cancel_d = cancel_q + CANCEL_W'(1);
  end

  // Cancel counter register.
  always_ff @(posedge clk) begin
    if (reset) cancel_q <= '0;
    else cancel_q <= cancel_d;
  end

  a_cancel_sat: assert property (@(posedge clk) disable iff (reset)
    !(cancel_inc && (cancel_q == '1)));
`endif

  a_rvalid_wait: assert property (@(posedge clk) disable iff (reset)
    data_rvalid |-> ((state_q == WAIT) || drop));

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: random + directed scoreboard bench for the
// MEM stage; flush scenario runs when MEM_STAGE_FLUSH_EN is set.
module tb_mem_stage_hs;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        exe_valid = 1'b0;
  logic [2:0]  exe_ld_op = '0;
  logic [2:0]  exe_wb_op = '0;
  logic [4:0]  exe_dest = '0;
  logic [31:0] exe_value = '0;
  logic [31:0] exe_pc = '0;
  logic        data_rvalid = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        wb_allowin = 1'b0;
  logic        mem_allowin, mem_valid, mem_ready_go;
  logic [2:0]  mem_wb_op;
  logic [4:0]  mem_dest;
  logic [31:0] mem_value, mem_pc;
  logic [3:0]  mem_wen;

  always #5 clk = ~clk;

  mem_stage_hs dut (
    .clk          (clk),
    .reset        (reset),
`ifdef MEM_STAGE_FLUSH_EN
    .flush        (flush),
`endif
    .exe_valid    (exe_valid),
    .mem_allowin  (mem_allowin),
    .exe_ld_op    (exe_ld_op),
    .exe_wb_op    (exe_wb_op),
    .exe_dest     (exe_dest),
    .exe_value    (exe_value),
    .exe_pc       (exe_pc),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .wb_allowin   (wb_allowin),
    .mem_valid    (mem_valid),
    .mem_ready_go (mem_ready_go),
    .mem_wb_op    (mem_wb_op),
    .mem_dest     (mem_dest),
    .mem_value    (mem_value),
    .mem_wen      (mem_wen),
    .mem_pc       (mem_pc)
  );

  typedef struct {
    logic [2:0]  ld;
    logic [2:0]  wb;
    logic [4:0]  dest;
    logic [31:0] value;
    logic [31:0] pc;
    logic [31:0] rd;
    int          dly;
  } instr_t;

  typedef struct packed {
    logic [31:0] value;
    logic [3:0]  wen;
    logic [4:0]  dest;
    logic [2:0]  wb;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } resp_t;

  exp_t   exp_q[$];
  resp_t  resp_q[$];
  int     n_tests = 0;
  int     n_fail = 0;
  int     cyc = 0;
  instr_t nop;

  // Reference: load result from byte-lane arithmetic on the word.
  function automatic exp_t model(input instr_t i);
    exp_t e;
    logic [31:0] d, bt, hf;
    int a;
    d = i.rd;
    a = int'(i.value[1:0]);
    bt = (d >> (8 * a)) & 32'hff;
    hf = (d >> (8 * a)) & 32'hffff;
    e.value = d;
    e.wen = 4'hf;
    case (i.ld)
      LD_NONE: e.value = i.value;
      LB: e.value = bt[7] ? (bt | 32'hffff_ff00) : bt;
      LBU: e.value = bt;
      LH, LHU: begin
        if (a % 2 == 1) begin
          e.value = '0;
          e.wen = 4'h0;
        end else if (i.ld == LH && hf[15]) begin
          e.value = hf | 32'hffff_0000;
        end else begin
          e.value = hf;
        end
      end
      LWL: begin
        e.value = d << (8 * (3 - a));
        e.wen = 4'(4'hf << (3 - a));
      end
      LWR: begin
        e.value = d >> (8 * a);
        e.wen = 4'(4'hf >> a);
      end
      default: e.value = d;
    endcase
    e.dest = i.dest;
    e.wb = i.wb;
    e.pc = i.pc;
    return e;
  endfunction

  function automatic instr_t mk(input logic [2:0] ld,
      input logic [31:0] value, input logic [31:0] rd,
      input int dly);
    instr_t i;
    i.ld = ld;
    i.wb = 3'($urandom);
    i.dest = 5'($urandom);
    i.value = value;
    i.pc = $urandom;
    i.rd = rd;
    i.dly = dly;
    return i;
  endfunction

  task automatic check(input string name,
      input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One cycle: drive at posedge+1, decide acceptance at negedge.
  task automatic tick(input bit v, input instr_t i,
      input int wbm, input bit fl, output bit acc);
    int due;
    @(posedge clk);
    #1;
    cyc++;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      data_rvalid = 1'b1;
      data_rdata = resp_q[0].d;
      void'(resp_q.pop_front());
    end else begin
      data_rvalid = 1'b0;
      data_rdata = $urandom;
    end
    if (wbm == 1) wb_allowin = 1'b1;
    else if (wbm == 2) wb_allowin = 1'b0;
    else wb_allowin = ($urandom_range(0, 3) != 0);
    flush = fl;
    exe_valid = v;
    exe_ld_op = i.ld;
    exe_wb_op = i.wb;
    exe_dest = i.dest;
    exe_value = i.value;
    exe_pc = i.pc;
    @(negedge clk);
    acc = v && mem_allowin && !fl;
    if (acc) begin
      exp_q.push_back(model(i));
      if (i.ld != LD_NONE) begin
        due = cyc + 1 + i.dly;
        if (resp_q.size() > 0 && resp_q[$].due >= due)
          due = resp_q[$].due + 1;
        resp_q.push_back('{due, i.rd});
      end
    end
  endtask

  task automatic send(input instr_t i, input int wbm,
      output int tries);
    bit acc;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      tick(1'b1, i, wbm, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept, expected one");
    end
  endtask

  task automatic idle(input int n, input int wbm);
    bit acc;
    repeat (n) tick(1'b0, nop, wbm, 1'b0, acc);
  endtask

  // Monitor: every WB handoff pops and checks one expected result.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (!reset && mem_valid && mem_ready_go && wb_allowin) begin
        n_tests++;
        got = '{mem_value, mem_wen, mem_dest, mem_wb_op, mem_pc};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_out: got %h, expected nothing", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL wb_out: got %h, expected %h", got, e);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    bit acc;
    instr_t i;
    nop = mk(LD_NONE, 32'h0, 32'h0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", mem_valid, 1'b0);
    check("rst_allowin", mem_allowin, 1'b1);
    check("rst_pc", mem_pc, 32'hbfc00000);
    check("rst_dest", mem_dest, 5'd0);
    check("rst_value", mem_value, 32'd0);
    check("rst_wen", mem_wen, 4'd0);
    check("rst_wb_op", mem_wb_op, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      send(mk(LD_NONE, $urandom, 32'h0, 0), 1, t);
      check("alu_b2b_tries", t, 1);
    end
    idle(1, 1);

    send(mk(LB, 32'h1000_0003, 32'h80FF_1234, 2), 1, t);
    for (int k = 0; k < 3; k++) begin
      idle(1, 1);
      check("lb_ready_go", mem_ready_go, k == 2);
      if (k == 2) check("lb_value", mem_value, 32'hFFFF_FF80);
    end

    send(mk(LWL, 32'h2000_0001, 32'hAABB_CCDD, 0), 1, t);
    for (int k = 0; k < 4; k++) begin
      idle(1, 2);
      check("lwl_ready_go", mem_ready_go, 1'b1);
      check("lwl_value", mem_value, 32'hCCDD_0000);
      check("lwl_wen", mem_wen, 4'b1100);
    end
    idle(1, 1);

    send(mk(LHU, 32'h3000_0002, 32'h8001_0000, 1), 1, t);
    send(mk(LD_NONE, 32'h0000_0042, 32'h0, 0), 1, t);
    check("add_on_handoff_tries", t, 2);
    idle(1, 1);

    send(mk(LW, 32'h4000_0000, 32'h5555_AAAA, 10), 1, t);
    idle(1, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exe_valid = 1'b0;
    data_rvalid = 1'b0;
    resp_q.delete();
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_wait_valid", mem_valid, 1'b0);
    check("rst_wait_pc", mem_pc, 32'hbfc00000);
    check("rst_wait_allowin", mem_allowin, 1'b1);

`ifdef MEM_STAGE_FLUSH_EN
    send(mk(LW, 32'h5000_0000, 32'h1111_1111, 2), 1, t);
    tick(1'b0, nop, 2, 1'b1, acc);
    void'(exp_q.pop_back());
    send(mk(LW, 32'h6000_0000, 32'h2222_2222, 0), 1, t);
    check("flush_new_lw_tries", t, 1);
    idle(1, 1);
    check("flush_drop_ready_go", mem_ready_go, 1'b0);
    idle(1, 1);
    check("flush_lw_ready_go", mem_ready_go, 1'b1);
    check("flush_lw_value", mem_value, 32'h2222_2222);
    idle(1, 1);
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 1) == 0) i = mk(LD_NONE, $urandom, 0, 0);
      else i = mk(3'($urandom_range(1, 7)), $urandom, $urandom,
                  $urandom_range(0, 3));
      send(i, 0, t);
      if ($urandom_range(0, 2) == 0) idle(1, 0);
    end

    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      idle(1, 1);
      t++;
    end
    check("drain_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Handshaked, parametrised memory pipeline stage between EXE and WB of the MIPS core.
- Accepts one instruction per cycle under a valid/allowin handshake.
- Waits a variable number of cycles for a load's data response, then buffers it.
- Aligns and extends load data (lb/lbu/lh/lhu/lw/lwl/lwr) and emits a per-byte register write mask for WB.

Parameters:
- DEST_W, 5, register-number width.
- WB_OP_W, 3, width of control bits passed through to WB.
- PC_RESET, 32'hbfc00000, reset value of mem_pc.
- CANCEL_W, 2, width of the flushed-load response cancel counter (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- exe_valid  in  1  EXE holds a valid instruction.
- mem_allowin  out  1  stage can accept this cycle.
- exe_ld_op  in  3  load op, encoding in package; 0 = not a load.
- exe_wb_op  in  WB_OP_W  pass-through WB control.
- exe_dest  in  DEST_W  destination register.
- exe_value  in  32  ALU result; for loads, the byte address.
- exe_pc  in  32  PC of the EXE instruction.
- data_rvalid  in  1  load data returned this cycle (one pulse per issued load).
- data_rdata  in  32  returned word, valid with data_rvalid.
- wb_allowin  in  1  WB can accept.
- mem_valid  out  1  stage holds a valid instruction.
- mem_ready_go  out  1  result is final (also used for forwarding).
- mem_wb_op  out  WB_OP_W  registered pass-through.
- mem_dest  out  DEST_W  registered destination.
- mem_value  out  32  final result.
- mem_wen  out  4  byte write mask for the register file.
- mem_pc  out  32  registered PC.
- flush  in  1  squash; port present only with the optional feature.

Behaviour:
- Reset: mem_valid=0, state EMPTY, mem_pc=PC_RESET, mem_dest=0, mem_wb_op=0, mem_value=0, mem_wen=0, buffer flag cleared.
- Accept: on a clk edge with exe_valid && mem_allowin, the stage registers ld_op, wb_op, dest, value and pc, and sets mem_valid=1.
  - The next state is WAIT if ld_op is nonzero, otherwise FULL.
- mem_allowin = !mem_valid || (mem_ready_go && wb_allowin). Back-to-back acceptance with no bubble is allowed.
- States:
  - EMPTY.
  - WAIT: load issued, data not yet returned.
  - FULL: result final.
- Transitions:
  - WAIT to FULL on data_rvalid. data_rdata is captured into a 32-bit buffer.
  - FULL or WAIT leaves on handoff (mem_ready_go && wb_allowin). It goes to EMPTY, or to WAIT/FULL if a new instruction is accepted in the same edge.
- mem_ready_go = (state==FULL) || (state==WAIT && data_rvalid). Same-cycle bypass: raw data is taken from data_rdata when rvalid is high in WAIT, otherwise from the buffer.
- Non-load: mem_value = registered exe_value, mem_wen = 4'b1111.
- Load alignment uses a = value[1:0] and raw word d:
  - lb/lbu: byte a, sign- or zero-extended; wen 1111.
  - lh/lhu: half at a=0 or a=2, sign- or zero-extended; wen 1111. Odd a gives value 0, wen 0000.
  - lw: d, wen 1111. The address is not checked.
  - lwl:
    - a=0: {d[7:0],24'b0}, wen 1000.
    - a=1: {d[15:0],16'b0}, wen 1100.
    - a=2: {d[23:0],8'b0}, wen 1110.
    - a=3: d, wen 1111.
  - lwr:
    - a=0: d, wen 1111.
    - a=1: {8'b0,d[31:8]}, wen 0111.
    - a=2: {16'b0,d[31:16]}, wen 0011.
    - a=3: {24'b0,d[31:24]}, wen 0001.
- mem_value and mem_wen are don't-care while !mem_ready_go. The bench must not check them then.
- data_rvalid while the state is not WAIT is a protocol error. It is ignored, and an assertion fires in simulation.
- Reset mid-WAIT returns the stage to EMPTY. The memory side is reset in the same cycle, so no late response is expected.

Optional Feature:
- MEM_STAGE_FLUSH_EN.
- Defined:
  - The flush port exists.
  - flush=1 clears mem_valid and forces EMPTY on the next edge. It overrides accept.
  - If flushed in WAIT without rvalid that cycle, a CANCEL_W-bit counter increments.
  - While the counter is nonzero, each data_rvalid is dropped and decrements it; the dropped response is not treated as a response for any new load.
  - A counter at max with another flush-in-WAIT saturates, and an assertion fires.
- Undefined: no flush port, no counter, and every rvalid belongs to the current WAIT.

Decomposition:
- Package mem_stage_pkg holds:
  - the load-op codes: LD_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWL=6, LWR=7;
  - state encodings EMPTY/WAIT/FULL;
  - the function-width constant 32.
- One sub-module, ld_align: purely combinational (ld_op, addr[1:0], raw) -> (value, wen), instantiated once.

Test Plan:
- Three back-to-back ALU ops with wb_allowin=1: mem_allowin stays 1, each result appears one cycle after accept, wen=1111.
- lb at addr 0x...3, data 0x80FF_1234, rvalid two cycles after accept: mem_ready_go asserts in the rvalid cycle, value=0xFFFF_FF80.
- lwl at a=1, d=0xAABBCCDD, with wb_allowin low for 3 cycles after rvalid: state FULL, buffer holds the word, value=0xCCDD_0000, wen=1100 until handoff.
- lhu at a=2, d=0x8001_0000, while a following add is offered: add is accepted on the handoff edge, lhu value=0x0000_8001.
- Reset asserted during WAIT: next cycle mem_valid=0, mem_pc=0xbfc00000, mem_allowin=1.
- With MEM_STAGE_FLUSH_EN: flush during WAIT, then a new lw accepted, then two rvalid pulses (0x1111_1111, then 0x2222_2222): the first is dropped, and lw value=0x2222_2222.
